// File: rtl/load_store_unit.sv
`default_nettype none
// ===========================================================================
// load_store_unit : byte-wide memory sequencer for 8/16-bit big-endian loads/stores
// Revision: 1.0
// ===========================================================================
module load_store_unit #(
  parameter int ADDR_W = 7
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              IsStore,
  input  logic              ByteMode,
  input  logic [15:0]       Address,
  input  logic [15:0]       WriteData,
  input  logic [7:0]        MemRdData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [7:0]        MemWrData,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [15:0]       ReadData,
  output logic              Busy,
  output logic              Done,
  output logic              AddrError
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACC_HI = 3'd1,
    S_ACC_LO = 3'd2,
    S_FIN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                is_store_q, is_store_d;
  logic                byte_mode_q, byte_mode_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [15:0]         rdata_q, rdata_d;
  logic                illegal;
  logic                rd_strobe, wr_strobe;

  // Out of range, or a halfword whose second byte would fall off the top.
  assign illegal = (|(Address >> ADDR_W)) ||
                   (!ByteMode && (Address[ADDR_W-1:0] == {ADDR_W{1'b1}}));

  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    byte_mode_d = byte_mode_q;
    err_d       = err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          is_store_d  = IsStore;
          byte_mode_d = ByteMode;
          addr_d      = Address[ADDR_W-1:0];
          wdata_d     = WriteData;
          err_d       = illegal;
          state_d     = illegal ? S_DONE : S_ACC_HI;
        end
      end
      S_ACC_HI: begin
        if (!byte_mode_q)    state_d = S_ACC_LO;
        else if (is_store_q) state_d = S_DONE;
        else                 state_d = S_FIN;
      end
      S_ACC_LO: begin
        if (is_store_q) begin
          state_d = S_DONE;
        end else begin
          rdata_d[15:8] = MemRdData;
          state_d       = S_FIN;
        end
      end
      S_FIN: begin
        rdata_d = byte_mode_q ? {8'h00, MemRdData} : {rdata_q[15:8], MemRdData};
        state_d = S_DONE;
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      is_store_q  <= 1'b0;
      byte_mode_q <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      byte_mode_q <= byte_mode_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    MemAddr   = '0;
    MemWrData = 8'h00;
    rd_strobe = 1'b0;
    wr_strobe = 1'b0;
    Busy      = (state_q != S_IDLE);
    Done      = (state_q == S_DONE);
    AddrError = (state_q == S_DONE) && err_q;
    case (state_q)
      S_ACC_HI: begin
        MemAddr   = addr_q;
        rd_strobe = !is_store_q;
        wr_strobe = is_store_q;
        if (is_store_q) MemWrData = byte_mode_q ? wdata_q[7:0] : wdata_q[15:8];
      end
      S_ACC_LO: begin
        MemAddr   = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        rd_strobe = !is_store_q;
        wr_strobe = is_store_q;
        if (is_store_q) MemWrData = wdata_q[7:0];
      end
      default: ;
    endcase
  end

  // Strobes are masked by Reset so an abandoned access never lands on the reset edge.
  assign MemRead  = rd_strobe && !Reset;
  assign MemWrite = wr_strobe && !Reset;
  assign ReadData = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ===========================================================================
// tb_load_store_unit : scoreboard bench with a byte memory model
// Revision: 1.0
// ===========================================================================
module tb_load_store_unit;
  localparam int ADDR_W = 7;

  logic              Clock = 1'b0;
  logic              Reset, Start, IsStore, ByteMode;
  logic [15:0]       Address, WriteData;
  logic [7:0]        MemRdData;
  logic [ADDR_W-1:0] MemAddr;
  logic [7:0]        MemWrData;
  logic              MemRead, MemWrite, Busy, Done, AddrError;
  logic [15:0]       ReadData;

  always #5 Clock = ~Clock;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .IsStore(IsStore),
    .ByteMode(ByteMode), .Address(Address), .WriteData(WriteData),
    .MemRdData(MemRdData), .MemAddr(MemAddr), .MemWrData(MemWrData),
    .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData),
    .Busy(Busy), .Done(Done), .AddrError(AddrError)
  );

  typedef struct {
    logic        err;
    logic [15:0] rd;
    int          start;
    int          lat;
    int          stb;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   strobes  = 0;
  logic mem_init = 1'b0;
  logic [7:0] mem [0:(1<<ADDR_W)-1];

  function automatic logic [7:0] init_val(input int a);
    return 8'(a) ^ 8'h5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) $display("FAIL %s: got %h, want %h", tag, got, want);
    else n_pass++;
  endtask

  always @(posedge Clock) cyc <= cyc + 1;

  // Memory: synchronous write, read data valid the cycle after MemRead.
  always @(posedge Clock) begin
    if (mem_init) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= init_val(i);
    end else begin
      if (MemWrite) mem[MemAddr] <= MemWrData;
      MemRdData <= MemRead ? mem[MemAddr] : 8'($urandom);
    end
  end

  always @(negedge Clock) begin
    exp_t e;
    if (Reset) begin
      strobes = 0;
    end else begin
      if (MemRead || MemWrite) begin
        strobes++;
        check("strobe_excl", {31'd0, MemRead & MemWrite}, 32'd0);
      end
      if (Done) begin
        done_cnt++;
        check("busy_in_done", {31'd0, Busy}, 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("addr_error", {31'd0, AddrError}, {31'd0, e.err});
          check("read_data", {16'd0, ReadData}, {16'd0, e.rd});
          check("latency", 32'(cyc - e.start + 1), 32'(e.lat));
          check("strobe_count", 32'(strobes), 32'(e.stb));
        end
        strobes = 0;
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_req(input logic st, input logic bm, input logic [15:0] a,
                        input logic [15:0] wd, input logic err, input logic [15:0] rd,
                        input int lat, input int nstb);
    exp_t e;
    int   n;
    bit   seen;
    IsStore = st; ByteMode = bm; Address = a; WriteData = wd; Start = 1'b1;
    n = done_cnt;
    tick();
    e.err = err; e.rd = rd; e.start = cyc; e.lat = lat; e.stb = nstb;
    exp_q.push_back(e);
    Start = 1'b0;
    IsStore = ~st; ByteMode = ~bm; Address = 16'($urandom); WriteData = 16'($urandom);
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      if (done_cnt != n) seen = 1;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    check({tag, "_done"}, {31'd0, Done}, 32'd0);
    check({tag, "_strobes_err"}, {29'd0, MemRead, MemWrite, AddrError}, 32'd0);
    check({tag, "_addr_wdata"}, {17'd0, MemAddr, MemWrData}, 32'd0);
  endtask

  initial begin
    int n;
    Reset = 1'b1; Start = 1'b0; IsStore = 1'b0; ByteMode = 1'b0;
    Address = '0; WriteData = '0; mem_init = 1'b1;
    tick(); tick();
    mem_init = 1'b0; Reset = 1'b0;
    check_idle_outputs("reset");
    check("reset_rdata", {16'd0, ReadData}, 32'd0);

    // Reset wins over Start.
    Reset = 1'b1; Start = 1'b1; Address = 16'h0010;
    tick();
    Reset = 1'b0; Start = 1'b0;
    tick();
    check("rst_prio_busy", {31'd0, Busy}, 32'd0);

    do_req(1'b1, 1'b0, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 3, 2);
    check("mem10", {24'd0, mem[16'h10]}, 32'hBE);
    check("mem11", {24'd0, mem[16'h11]}, 32'hEF);
    do_req(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF, 4, 2);
    do_req(1'b1, 1'b1, 16'h0020, 16'h12A5, 1'b0, 16'hBEEF, 2, 1);
    check("mem20", {24'd0, mem[16'h20]}, 32'hA5);
    check("mem21", {24'd0, mem[16'h21]}, {24'd0, init_val(16'h21)});
    do_req(1'b0, 1'b1, 16'h0020, 16'h0000, 1'b0, 16'h00A5, 3, 1);
    do_req(1'b0, 1'b0, 16'h007F, 16'h0000, 1'b1, 16'h00A5, 1, 0);
    do_req(1'b0, 1'b1, 16'h0080, 16'h0000, 1'b1, 16'h00A5, 1, 0);
    do_req(1'b1, 1'b0, 16'h007F, 16'hFFFF, 1'b1, 16'h00A5, 1, 0);
    check("mem7f_kept", {24'd0, mem[16'h7F]}, {24'd0, init_val(16'h7F)});
    check_idle_outputs("idle");
    do_req(1'b0, 1'b1, 16'h007F, 16'h0000, 1'b0, {8'h00, init_val(16'h7F)}, 3, 1);
    do_req(1'b0, 1'b0, 16'h007E, 16'h0000, 1'b0, {init_val(16'h7E), init_val(16'h7F)}, 4, 2);

    // Start held high through a whole halfword load, with a store request on the bus.
    begin
      exp_t e;
      n = done_cnt;
      IsStore = 1'b0; ByteMode = 1'b0; Address = 16'h0010; Start = 1'b1;
      tick();
      e.err = 1'b0; e.rd = 16'hBEEF; e.start = cyc; e.lat = 4; e.stb = 2;
      exp_q.push_back(e);
      IsStore = 1'b1; ByteMode = 1'b1; Address = 16'h0020; WriteData = 16'hFFFF;
      for (int i = 0; i < 4; i++) tick();
      Start = 1'b0;
      tick();
      check("no_queue_busy", {31'd0, Busy}, 32'd0);
      check("single_done", 32'(done_cnt - n), 32'd1);
      check("mem20_kept", {24'd0, mem[16'h20]}, 32'hA5);
    end
    do_req(1'b0, 1'b1, 16'h0011, 16'h0000, 1'b0, 16'h00EF, 3, 1);

    // Reset during the second byte of a halfword store.
    IsStore = 1'b1; ByteMode = 1'b0; Address = 16'h0030; WriteData = 16'h1234; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    n = done_cnt;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_idle_outputs("midrst");
    check("midrst_rdata", {16'd0, ReadData}, 32'd0);
    tick(); tick(); tick();
    check("midrst_no_done", 32'(done_cnt - n), 32'd0);
    check("mem30", {24'd0, mem[16'h30]}, 32'h12);
    check("mem31", {24'd0, mem[16'h31]}, {24'd0, init_val(16'h31)});
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 7: byte-address width of the data memory (2^ADDR_W bytes).
REQ-002 Clock  input  1  single clock; all state changes on the rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request strobe, sampled only in IDLE.
REQ-005 IsStore  input  1  1 = store, 0 = load; latched at Start.
REQ-006 ByteMode  input  1  1 = single byte, 0 = big-endian halfword; latched at Start.
REQ-007 Address  input  16  byte address; latched at Start.
REQ-008 WriteData  input  16  store data; latched at Start.
REQ-009 MemRdData  input  8  memory read byte, valid the cycle after MemRead.
REQ-010 MemAddr  output  ADDR_W  memory byte address.
REQ-011 MemWrData  output  8  memory write byte.
REQ-012 MemRead / MemWrite  output  1 each  memory strobes, never both high.
REQ-013 ReadData  output  16  load result.
REQ-014 Busy  output  1  high whenever state is not IDLE.
REQ-015 Done  output  1  one-cycle completion pulse.
REQ-016 AddrError  output  1  request rejected; valid only while Done is high.

Function
REQ-017 States SHALL be IDLE, ACC_HI, ACC_LO, FIN, DONE. Outputs SHALL be Moore-decoded from the state and latched request.
REQ-018 In IDLE with Start=1, the unit SHALL latch IsStore, ByteMode, Address and WriteData (A = latched address).
- If the request is legal, the next state SHALL be ACC_HI.
- If it is illegal, the next state SHALL be DONE.
REQ-019 A request SHALL be illegal if Address[15:ADDR_W] is nonzero, or if it is a halfword with A = 2^ADDR_W-1.
REQ-020 For an illegal request, DONE SHALL assert AddrError=1. MemRead and MemWrite SHALL stay low for the whole request. ReadData SHALL be unchanged.
REQ-021 ACC_HI SHALL drive MemAddr=A.
- Load: MemRead=1.
- Store: MemWrite=1, MemWrData=WriteData[15:8] for a halfword or WriteData[7:0] for a byte.
REQ-022 ACC_LO (halfword only) SHALL drive MemAddr=A+1.
- Load: MemRead=1.
- Store: MemWrite=1, MemWrData=WriteData[7:0].
REQ-023 The halfword load sequence SHALL be IDLE>ACC_HI>ACC_LO>FIN>DONE>IDLE.
- Edge leaving ACC_LO: ReadData[15:8] <= MemRdData.
- Edge leaving FIN: ReadData[7:0] <= MemRdData.
REQ-024 The byte load sequence SHALL be IDLE>ACC_HI>FIN>DONE>IDLE.
- Edge leaving FIN: ReadData <= {8'h00, MemRdData} (zero-extended).
REQ-025 The halfword store sequence SHALL be IDLE>ACC_HI>ACC_LO>DONE>IDLE. The byte store sequence SHALL be IDLE>ACC_HI>DONE>IDLE.
REQ-026 Latency from the Start-sampling edge to Done high SHALL be:
- halfword load: 4 cycles
- byte load: 3 cycles
- halfword store: 3 cycles
- byte store: 2 cycles
- illegal request: 1 cycle
REQ-027 Done SHALL be high exactly one cycle (state DONE), and Busy SHALL also be high in that cycle. A new Start SHALL be accepted in the cycle after DONE at the earliest.
REQ-028 Start while Busy=1 SHALL be ignored and not queued. Input changes after the Start-sampling edge SHALL have no effect on the request in flight.
REQ-029 Stores SHALL never modify ReadData. ReadData SHALL hold its value until the next load capture.
REQ-030 When idle, MemAddr and MemWrData SHALL be 0, and MemRead, MemWrite and AddrError SHALL be 0.

Reset
REQ-031 Reset=1 at a rising edge SHALL force state IDLE and ReadData=16'h0000. Busy, Done, AddrError, MemRead, MemWrite, MemAddr and MemWrData SHALL all be 0 from that edge on.
REQ-032 Reset SHALL take priority over Start.
REQ-033 Reset mid-operation SHALL abandon the request with no further strobes.
- Bytes already written before the reset SHALL remain in memory.
- No Done pulse SHALL be issued for the abandoned request.

Verification
REQ-034 Halfword store then load: store A=16'h0010, WriteData=16'hBEEF.
- Expected writes: byte 0x10 <= 0xBE, byte 0x11 <= 0xEF; Done 3 cycles after Start.
- Then a halfword load at 0x10 -> ReadData=16'hBEEF, Done 4 cycles after Start.
REQ-035 Byte path: byte store of WriteData=16'h12A5 at 0x20 writes 0xA5 only. A byte load at 0x20 -> ReadData=16'h00A5 after 3 cycles.
REQ-036 Illegal requests, each -> Done after 1 cycle with AddrError=1, no memory strobes, ReadData unchanged:
- halfword load at 0x007F
- byte load at 0x0080
REQ-037 Start pulsed in every cycle of a halfword load: only the first request executes. Exactly one Done occurs, then the next Start is accepted in IDLE.
REQ-038 Reset asserted in ACC_LO of a halfword store at 0x30 with WriteData=16'h1234:
- byte 0x30 = 0x12; byte 0x31 unchanged.
- No Done; all outputs 0 the cycle after the reset edge.
